// File: rtl/sweep_stim_misr.sv
// Exhaustive two-operand sweep generator that compacts the result of a combinational
// unit under test into a 16-bit MISR signature, behind a start/done handshake.
module sweep_stim_misr #(
  parameter int WIDTH = 3,
  parameter int DWELL = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             vec_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      signature_o
);

  localparam int IW = 2 * WIDTH;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_LAST = {IW{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [15:0]   sig_q, sig_d;
  logic          fb;
  logic [15:0]   misr_next;

  assign fb        = sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10];
  assign misr_next = {sig_q[14:0], fb} ^ {{(16 - WIDTH){1'b0}}, y_i};

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dwell_q <= '0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      sig_q   <= sig_d;
    end
  end

  // Abort outranks the end-of-dwell sample, so an aborted vector never reaches the MISR.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    sig_d   = sig_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          idx_d   = '0;
          dwell_d = '0;
          sig_d   = '0;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
          idx_d   = '0;
          dwell_d = '0;
        end else if (dwell_q == DWELL_LAST) begin
          sig_d   = misr_next;
          dwell_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
        dwell_d = '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        dwell_d = '0;
      end
    endcase
  end

  always_comb begin
    vec_valid_o = (state_q == RUN);
    busy_o      = (state_q == RUN);
    done_o      = (state_q == DONE);
    a_o         = (state_q == RUN) ? idx_q[IW-1:WIDTH] : '0;
    b_o         = (state_q == RUN) ? idx_q[WIDTH-1:0] : '0;
    signature_o = sig_q;
  end

endmodule

// File: tb/tb_sweep_stim_misr.sv
// Scoreboard bench for sweep_stim_misr: three instances with different WIDTH/DWELL,
// stimulus pushes expected vectors and done records, a negedge monitor pops and compares.
module tb_sweep_stim_misr;

  typedef struct packed {
    int cyc;
    int a;
    int b;
    int sig;
  } rec_t;

  logic clk;
  logic rstN;
  logic start;
  logic abort;
  logic yZero;
  logic [1:0] sel;
  logic [2:0] startV;
  logic [2:0] abortV;
  int cyc;
  int checks;
  int errors;
  bit monOn;
  int expIdle [3];
  rec_t runQ [$];
  rec_t doneQ [$];

  logic [0:0] a0, b0, y0;
  logic [2:0] a1, b1, y1, a2, b2, y2;
  logic vv0, vv1, vv2, busy0, busy1, busy2, done0, done1, done2;
  logic [15:0] sig0, sig1, sig2;
  logic [7:0] mA, mB;
  logic mVv, mBusy, mDone;
  logic [15:0] mSig;

  assign startV = start ? (3'b001 << sel) : 3'b000;
  assign abortV = abort ? (3'b001 << sel) : 3'b000;
  assign y0 = 1'b1;
  assign y1 = a1 ^ b1;
  assign y2 = yZero ? 3'd0 : (a2 ^ b2);

  sweep_stim_misr #(.WIDTH(1), .DWELL(1)) dut0 (
    .clk_i(clk), .rst_n_i(rstN), .start_i(startV[0]), .abort_i(abortV[0]), .y_i(y0),
    .a_o(a0), .b_o(b0), .vec_valid_o(vv0), .busy_o(busy0), .done_o(done0), .signature_o(sig0)
  );
  sweep_stim_misr #(.WIDTH(3), .DWELL(3)) dut1 (
    .clk_i(clk), .rst_n_i(rstN), .start_i(startV[1]), .abort_i(abortV[1]), .y_i(y1),
    .a_o(a1), .b_o(b1), .vec_valid_o(vv1), .busy_o(busy1), .done_o(done1), .signature_o(sig1)
  );
  sweep_stim_misr #(.WIDTH(3), .DWELL(1)) dut2 (
    .clk_i(clk), .rst_n_i(rstN), .start_i(startV[2]), .abort_i(abortV[2]), .y_i(y2),
    .a_o(a2), .b_o(b2), .vec_valid_o(vv2), .busy_o(busy2), .done_o(done2), .signature_o(sig2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    mA = 8'd0; mB = 8'd0; mVv = 1'b0; mBusy = 1'b0; mDone = 1'b0; mSig = 16'd0;
    case (sel)
      2'd0: begin mA = {7'd0, a0}; mB = {7'd0, b0}; mVv = vv0; mBusy = busy0; mDone = done0; mSig = sig0; end
      2'd1: begin mA = {5'd0, a1}; mB = {5'd0, b1}; mVv = vv1; mBusy = busy1; mDone = done1; mSig = sig1; end
      default: begin mA = {5'd0, a2}; mB = {5'd0, b2}; mVv = vv2; mBusy = busy2; mDone = done2; mSig = sig2; end
    endcase
  end

  function automatic logic [15:0] misr(input logic [15:0] s, input int y);
    logic fb;
    logic [15:0] yv;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    yv = 16'(y);
    return {s[14:0], fb} ^ yv;
  endfunction

  function automatic int yModel(input int s, input int a, input int b);
    if (s == 0) return 1;
    if (s == 2 && yZero) return 0;
    return a ^ b;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h (dut %0d)", name, cyc, actual, expected, sel);
    end
  endtask

  // Monitor: pops one record per RUN cycle, one per done pulse, and checks idle otherwise.
  always @(negedge clk) begin : monitor
    rec_t r;
    if (monOn) begin
      if (mVv) begin
        if (runQ.size() == 0) begin
          checkOutput("unexpected_vec", 1, 0);
        end else begin
          r = runQ.pop_front();
          checkOutput("run_cyc", cyc, r.cyc);
          checkOutput("run_a", int'(mA), r.a);
          checkOutput("run_b", int'(mB), r.b);
          checkOutput("run_sig", int'(mSig), r.sig);
          checkOutput("run_flags", int'({mBusy, mDone}), 2);
        end
      end else if (mDone) begin
        if (doneQ.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          r = doneQ.pop_front();
          checkOutput("done_cyc", cyc, r.cyc);
          checkOutput("done_sig", int'(mSig), r.sig);
          checkOutput("done_outs", int'({mBusy, mA, mB}), 0);
        end
      end else begin
        checkOutput("idle_outs", int'({mBusy, mA, mB}), 0);
        checkOutput("idle_sig", int'(mSig), expIdle[sel]);
      end
    end
  end

  // One test: issue start in cycle 0, model nSweeps sweeps (or a truncated one), then drain.
  task automatic applyStimulus(input int s, input int nSweeps, input int abortAt,
                               input int rstAt, input bit abortWithStart);
    int w, d, n, c0, base, limit, k, budget;
    logic [15:0] sig;
    rec_t r;
    w = (s == 0) ? 1 : 3;
    d = (s == 1) ? 3 : 1;
    n = 1 << (2 * w);
    sig = 16'd0;
    @(posedge clk); #1;
    sel = 2'(s);
    start = 1'b1;
    abort = abortWithStart;
    c0 = cyc;
    for (int j = 0; j < nSweeps; j++) begin
      base = c0 + j * (n * d + 2);
      sig = 16'd0;
      limit = (abortAt > 0) ? abortAt : ((rstAt > 0) ? rstAt : n * d);
      for (int c = 1; c <= limit; c++) begin
        k = (c - 1) / d;
        r.cyc = base + c;
        r.a = k >> w;
        r.b = k & ((1 << w) - 1);
        r.sig = int'(sig);
        runQ.push_back(r);
        if ((c % d == 0) && !(abortAt > 0 && c == limit) && !(rstAt > 0 && c == limit))
          sig = misr(sig, yModel(s, r.a, r.b));
      end
      if (abortAt <= 0 && rstAt <= 0) begin
        r.cyc = base + n * d + 1;
        r.a = 0;
        r.b = 0;
        r.sig = int'(sig);
        doneQ.push_back(r);
      end
    end
    @(posedge clk); #1;
    abort = 1'b0;
    if (rstAt > 0) begin
      for (int i = 0; i < 3; i++) expIdle[i] = 0;
    end else begin
      expIdle[s] = int'(sig);
    end
    if (nSweeps == 1) start = 1'b0;
    if (nSweeps > 1) begin
      repeat ((nSweeps - 1) * (n * d + 2)) @(posedge clk);
      #1 start = 1'b0;
    end
    if (abortAt > 0) begin
      repeat (abortAt - 1) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
    end
    if (rstAt > 0) begin
      repeat (rstAt - 1) @(posedge clk);
      #1 rstN = 1'b0;
      @(posedge clk); #1 rstN = 1'b1;
    end
    budget = 0;
    while ((runQ.size() != 0 || doneQ.size() != 0) && budget < 3000) begin
      @(posedge clk);
      budget++;
    end
    if (budget >= 3000) begin
      checkOutput("drain_timeout", runQ.size() + doneQ.size(), 0);
      runQ.delete();
      doneQ.delete();
    end
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    monOn = 1'b0;
    rstN = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    yZero = 1'b0;
    sel = 2'd0;
    for (int i = 0; i < 3; i++) expIdle[i] = 0;
    @(posedge clk); #1;
    monOn = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    repeat (3) @(posedge clk);

    applyStimulus(0, 1, 0, 0, 1'b0);
    applyStimulus(0, 2, 0, 0, 1'b1);
    applyStimulus(1, 1, 0, 0, 1'b0);
    applyStimulus(2, 1, 10, 0, 1'b0);
    applyStimulus(2, 1, 0, 0, 1'b0);
    #1 yZero = 1'b1;
    applyStimulus(2, 1, 0, 0, 1'b0);
    #1 yZero = 1'b0;
    applyStimulus(1, 1, 0, 20, 1'b0);

    checkOutput("queues_empty", runQ.size() + doneQ.size(), 0);
    @(posedge clk); #1;
    monOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sweep_stim_misr.md
# sweep_stim_misr

Synthesizable stimulus-and-response stage that drives an exhaustive sweep of two WIDTH-bit operands into a combinational unit under test and compacts its WIDTH-bit result into a 16-bit MISR signature. It sits directly upstream of the unit under test, driving `a`/`b`, and directly downstream of it, consuming `y`. It replaces hand-written per-vector stimulus with a single start/done handshake. Sweep order is `a` outer and `b` inner, so `b` counts 0..max for each `a` value.

## Interface
- WIDTH, 3, bit width of each operand and of `y`; legal range 1..8.
- DWELL, 1, cycles each vector is held; must be ≥1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset. Reset is synchronous and active-low, on the single clock `clk`.
- start  in  1  begin a sweep. Sampled only in IDLE.
- abort  in  1  terminate a running sweep. Sampled only in RUN.
- y  in  WIDTH  result from the unit under test (combinational from `a`/`b`).
- a  out  WIDTH  operand A to the unit under test.
- b  out  WIDTH  operand B to the unit under test.
- vec_valid  out  1  high while `a`/`b` carry a sweep vector.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a full sweep completes.
- signature  out  16  MISR value.

## Operation
- Reset values (rst_n=0 at an edge): state IDLE, `a`=0, `b`=0, `vec_valid`=0, `busy`=0, `done`=0, `signature`=16'h0000, index=0, dwell count=0.
- Internal index: 2·WIDTH bits. `a` = idx[2W-1:W], `b` = idx[W-1:0]. Vector count N = 2^(2·WIDTH).
- States:
  - IDLE: outputs hold their reset values, except that `signature` holds its last value.
    - start=1 → go to RUN. Clear idx, dwell count and signature to 0.
  - RUN: `busy`=1, `vec_valid`=1.
    - The dwell counter counts 0..DWELL-1.
    - On the edge ending dwell count DWELL-1: update the MISR with the current `y`. Then, if idx = N-1, go to DONE; otherwise increment idx and clear the dwell count.
    - abort=1 → go to IDLE with no MISR update that edge, `done` not pulsed, and `signature` holding the partial value. Abort takes priority over the sample/advance.
  - DONE: `done`=1 for exactly one cycle, `busy`=0, `vec_valid`=0, `a`=`b`=0, signature frozen. Unconditionally go to IDLE.
- MISR, with s = signature:
  - fb = s[15]^s[13]^s[12]^s[10]
  - s_next = {s[14:0], fb} ^ {zero-extension to 16 bits, y}
- Boundaries:
  - start while in RUN or DONE: ignored.
  - start and abort together in IDLE: start wins; abort is not sampled in IDLE.
  - start in the cycle immediately after DONE (IDLE) begins a new sweep.
  - rst_n low mid-sweep: next edge forces all reset values, including signature=0. There is no resume.
  - idx wraps never: the sweep terminates at N-1.

## Timing
- Cycle 0: start=1 sampled at the edge ending this cycle.
- Cycle 1: RUN, `a`=`b`=0, `busy`=1.
- Vector k is driven during cycles k·DWELL+1 … (k+1)·DWELL. `y` is sampled at the edge ending cycle (k+1)·DWELL.
- `done` is high in cycle N·DWELL+1. `signature` is final in that cycle and holds until the next start or reset.
- Latency start→done = N·DWELL+1 cycles.
- `y` must settle within one cycle of an `a`/`b` change (the unit under test is combinational). With DWELL=1 it is sampled in the same cycle it is driven.

## Test plan
- WIDTH=1, DWELL=1, y tied to 1, pulse start:
  - `a`,`b` sequence (0,0),(0,1),(1,0),(1,1) in cycles 1–4.
  - done in cycle 5.
  - signature progression 0001, 0003, 0007, 000F; final 16'h000F.
- WIDTH=3, DWELL=3, y = a ^ b from a reference model:
  - `a`/`b` change every 3 cycles and visit all 64 pairs in `a`-outer/`b`-inner order.
  - done at cycle 193.
  - signature equals the software MISR model.
- WIDTH=3, DWELL=1, y tied to 0: signature stays 16'h0000 throughout, and done occurs at cycle 65.
- WIDTH=3, abort asserted at cycle 10:
  - Next cycle: IDLE with busy=0, no done pulse, and signature equal to the model after 9 samples.
  - A subsequent start restarts from `a`=`b`=0 with signature cleared.
- Start behaviour:
  - start held high continuously: exactly one sweep per IDLE entry; start pulses while busy have no effect.
  - A back-to-back sweep begins the cycle after done.
- rst_n driven low at cycle 20 of a sweep: the next edge shows all reset values (signature=0, busy=0, a=b=0), and no done follows.
